// File: rtl/player_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : player_controller_pkg
// Description : Shared grid limits, orientation/FSM encodings and tile helper
//               for the player controller, frame buffer controller and game logic.
// Revision    : 1.0 - initial release
// ============================================================================
package player_controller_pkg;

    localparam int         GRID_COLS     = 16;
    localparam int         GRID_ROWS     = 12;
    localparam logic [3:0] UNUSED_ID     = 4'hF;
    localparam logic [7:0] START_LOC     = 8'h57;
    localparam logic [13:0] UNUSED_ENTITY = {UNUSED_ID, 10'h000};

    typedef enum logic [1:0] {
        ORI_UP    = 2'b00,
        ORI_RIGHT = 2'b01,
        ORI_DOWN  = 2'b10,
        ORI_LEFT  = 2'b11
    } orient_t;

    typedef enum logic [1:0] {
        ATK_IDLE     = 2'd0,
        ATK_ACTIVE   = 2'd1,
        ATK_COOLDOWN = 2'd2
    } atk_state_t;

    // Returns {on_grid, location} of the tile next to loc in direction ori;
    // when the neighbour is off-grid the original location is returned.
    function automatic logic [8:0] adjacent_tile(input logic [7:0] loc, input orient_t ori);
        logic [3:0] row;
        logic [3:0] col;
        logic       ok;
        row = loc[7:4];
        col = loc[3:0];
        ok  = 1'b0;
        case (ori)
            ORI_UP: begin
                ok  = (row != 4'd0);
                row = row - 4'd1;
            end
            ORI_DOWN: begin
                ok  = (row != 4'(GRID_ROWS - 1));
                row = row + 4'd1;
            end
            ORI_LEFT: begin
                ok  = (col != 4'd0);
                col = col - 4'd1;
            end
            default: begin
                ok  = (col != 4'(GRID_COLS - 1));
                col = col + 4'd1;
            end
        endcase
        return ok ? {1'b1, row, col} : {1'b0, loc};
    endfunction

endpackage
`default_nettype wire

// File: rtl/player_controller_frame_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : frame_tick_gen
// Description : Synchronises vsync and emits a one-cycle pulse per rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic i_vsync,
    output logic o_frame_tick
);

    logic r_vs_meta;
    logic r_vs_sync;
    logic r_vs_prev;
    logic r_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vs_meta <= 1'b0;
            r_vs_sync <= 1'b0;
            r_vs_prev <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_vs_meta <= i_vsync;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
            r_tick    <= r_vs_sync & ~r_vs_prev;
        end
    end

    assign o_frame_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/player_controller.sv
`default_nettype none
// ============================================================================
// Module      : player_controller
// Description : Grid movement of the player and sword attack FSM, frame paced.
// Revision    : 1.0 - initial release
// ============================================================================
module player_controller
    import player_controller_pkg::*;
#(
    parameter int         MOVE_PERIOD     = 8,
    parameter int         SWORD_FRAMES    = 4,
    parameter int         COOLDOWN_FRAMES = 8,
    parameter logic [3:0] PLAYER_ID       = 4'h1,
    parameter logic [3:0] SWORD_ID        = 4'h2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  buttons,
    input  logic        attack,
    input  logic        vsync,
    output logic [13:0] player_entity,
    output logic [13:0] sword_entity
);

    localparam int MC_W   = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam int FC_MAX = (SWORD_FRAMES > COOLDOWN_FRAMES) ? SWORD_FRAMES : COOLDOWN_FRAMES;
    localparam int FC_W   = (FC_MAX > 1) ? $clog2(FC_MAX) : 1;

    localparam logic [MC_W-1:0] MOVE_MAX   = MC_W'(MOVE_PERIOD - 1);
    localparam logic [MC_W-1:0] MC_ONE     = MC_W'(1);
    localparam logic [FC_W-1:0] SWORD_LOAD = FC_W'(SWORD_FRAMES - 1);
    localparam logic [FC_W-1:0] COOL_LOAD  = FC_W'(COOLDOWN_FRAMES - 1);
    localparam logic [FC_W-1:0] FC_ONE     = FC_W'(1);
    localparam logic [FC_W-1:0] FC_ZERO    = '0;

    logic [3:0]      r_btn_meta;
    logic [3:0]      r_btn_sync;
    logic            r_atk_meta;
    logic            r_atk_sync;
    logic            r_atk_prev;
    logic            r_press;
    atk_state_t      r_state;
    logic [FC_W-1:0] r_fcnt;
    logic [MC_W-1:0] r_mcnt;
    logic [7:0]      r_loc;
    orient_t         r_ori;
    logic [13:0]     r_sword;

    logic            w_tick;
    logic            w_atk_edge;
    logic            w_dir_held;
    orient_t         w_dir;
    atk_state_t      w_state_nx;
    logic [FC_W-1:0] w_fcnt_nx;
    logic            w_press_nx;
    logic [MC_W-1:0] w_mcnt_nx;
    logic [7:0]      w_loc_nx;
    orient_t         w_ori_nx;
    logic [13:0]     w_sword_nx;
    logic [8:0]      w_step;
    logic [8:0]      w_sword_tile;

    frame_tick_gen u_frame_tick_gen (
        .clk          (clk),
        .reset        (reset),
        .i_vsync      (vsync),
        .o_frame_tick (w_tick)
    );

    assign w_atk_edge = r_atk_sync & ~r_atk_prev;
    assign w_dir_held = |r_btn_sync;

    // buttons = {right, left, down, up}; priority up > down > left > right
    always_comb begin
        w_dir = ORI_RIGHT;
        if (r_btn_sync[0])      w_dir = ORI_UP;
        else if (r_btn_sync[1]) w_dir = ORI_DOWN;
        else if (r_btn_sync[2]) w_dir = ORI_LEFT;
    end

    always_comb begin
        w_state_nx = r_state;
        w_fcnt_nx  = r_fcnt;
        w_press_nx = 1'b0;
        case (r_state)
            ATK_IDLE: begin
                w_press_nx = r_press | w_atk_edge;
                if (w_tick && w_press_nx) begin
                    w_state_nx = ATK_ACTIVE;
                    w_fcnt_nx  = SWORD_LOAD;
                    w_press_nx = 1'b0;
                end
            end
            ATK_ACTIVE: begin
                if (w_tick) begin
                    if (r_fcnt == FC_ZERO) begin
                        w_state_nx = ATK_COOLDOWN;
                        w_fcnt_nx  = COOL_LOAD;
                    end else begin
                        w_fcnt_nx  = r_fcnt - FC_ONE;
                    end
                end
            end
            ATK_COOLDOWN: begin
                if (w_tick) begin
                    if (r_fcnt == FC_ZERO) begin
                        w_state_nx = ATK_IDLE;
                    end else begin
                        w_fcnt_nx  = r_fcnt - FC_ONE;
                    end
                end
            end
            default: begin
                w_state_nx = ATK_IDLE;
                w_fcnt_nx  = FC_ZERO;
            end
        endcase
    end

    always_comb begin
        w_mcnt_nx    = r_mcnt;
        w_loc_nx     = r_loc;
        w_ori_nx     = r_ori;
        w_sword_nx   = r_sword;
        w_step       = adjacent_tile(r_loc, w_dir);
        w_sword_tile = 9'h000;
        if (w_tick) begin
            // a move attempt into a border still consumes the period
            if (w_dir_held && (r_mcnt == MOVE_MAX) && (r_state != ATK_ACTIVE)) begin
                w_mcnt_nx = '0;
                w_loc_nx  = w_step[7:0];
            end else if (r_mcnt != MOVE_MAX) begin
                w_mcnt_nx = r_mcnt + MC_ONE;
            end
            if (w_dir_held && (r_state != ATK_ACTIVE)) begin
                w_ori_nx = w_dir;
            end
            w_sword_tile = adjacent_tile(w_loc_nx, w_ori_nx);
            if (w_state_nx == ATK_ACTIVE) begin
                w_sword_nx = {(w_sword_tile[8] ? SWORD_ID : UNUSED_ID), w_ori_nx, w_sword_tile[7:0]};
            end else begin
                w_sword_nx = UNUSED_ENTITY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_meta <= 4'h0;
            r_btn_sync <= 4'h0;
            r_atk_meta <= 1'b0;
            r_atk_sync <= 1'b0;
            r_atk_prev <= 1'b0;
            r_press    <= 1'b0;
            r_state    <= ATK_IDLE;
            r_fcnt     <= '0;
            r_mcnt     <= '0;
            r_loc      <= START_LOC;
            r_ori      <= ORI_UP;
            r_sword    <= UNUSED_ENTITY;
        end else begin
            r_btn_meta <= buttons;
            r_btn_sync <= r_btn_meta;
            r_atk_meta <= attack;
            r_atk_sync <= r_atk_meta;
            r_atk_prev <= r_atk_sync;
            r_press    <= w_press_nx;
            r_state    <= w_state_nx;
            r_fcnt     <= w_fcnt_nx;
            r_mcnt     <= w_mcnt_nx;
            r_loc      <= w_loc_nx;
            r_ori      <= w_ori_nx;
            r_sword    <= w_sword_nx;
        end
    end

    assign player_entity = {PLAYER_ID, r_ori, r_loc};
    assign sword_entity  = r_sword;

endmodule
`default_nettype wire

// File: tb/tb_player_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_controller
// Description : Directed frame-level bench for player_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_controller;

    logic        clk;
    logic        reset;
    logic [3:0]  buttons;
    logic        attack;
    logic        vsync;
    logic [13:0] player_entity;
    logic [13:0] sword_entity;

    int n_tests;
    int n_fail;

    localparam logic [13:0] C_UNUSED = 14'h3C00;
    localparam logic [3:0]  C_UP     = 4'b0001;
    localparam logic [3:0]  C_DOWN   = 4'b0010;
    localparam logic [3:0]  C_LEFT   = 4'b0100;
    localparam logic [3:0]  C_RIGHT  = 4'b1000;

    player_controller u_dut (
        .clk           (clk),
        .reset         (reset),
        .buttons       (buttons),
        .attack        (attack),
        .vsync         (vsync),
        .player_entity (player_entity),
        .sword_entity  (sword_entity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] pe(input logic [1:0] ori, input logic [7:0] loc);
        return {4'h1, ori, loc};
    endfunction

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic run_frame();
        @(negedge clk) vsync = 1'b1;
        repeat (4) @(negedge clk);
        vsync = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic run_frames(input int n);
        for (int k = 0; k < n; k++) run_frame();
    endtask

    task automatic pulse_attack();
        @(negedge clk) attack = 1'b1;
        repeat (3) @(negedge clk);
        attack = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        buttons = 4'h0;
        attack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        buttons = 4'h0;
        attack  = 1'b0;
        vsync   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_player", player_entity, pe(2'b00, 8'h57));
        check("rst_sword", sword_entity, C_UNUSED);

        // hold up: moves at frame 8 and 16
        buttons = C_UP;
        for (int f = 1; f <= 20; f++) begin
            run_frame();
            if (f == 7)  check("up_f7",  player_entity, pe(2'b00, 8'h57));
            if (f == 8)  check("up_f8",  player_entity, pe(2'b00, 8'h47));
            if (f == 15) check("up_f15", player_entity, pe(2'b00, 8'h47));
            if (f == 16) check("up_f16", player_entity, pe(2'b00, 8'h37));
            if (f == 20) check("up_f20", player_entity, pe(2'b00, 8'h37));
        end

        // up+left held: only row moves
        do_reset();
        buttons = C_UP | C_LEFT;
        run_frames(8);
        check("upleft", player_entity, pe(2'b00, 8'h47));
        buttons = C_UP;
        run_frames(32);
        check("reach_top", player_entity, pe(2'b00, 8'h07));
        run_frames(16);
        check("top_clamp", player_entity, pe(2'b00, 8'h07));

        // walk to bottom-right corner, then push right into the border
        do_reset();
        buttons = C_RIGHT;
        run_frames(64);
        check("reach_right", player_entity, pe(2'b01, 8'h5F));
        buttons = C_DOWN;
        run_frames(48);
        check("reach_corner", player_entity, pe(2'b10, 8'hBF));
        buttons = C_RIGHT;
        run_frames(16);
        check("corner_clamp", player_entity, pe(2'b01, 8'hBF));

        // attack facing right at 0x57
        do_reset();
        buttons = C_RIGHT;
        run_frame();
        buttons = 4'h0;
        check("face_right", player_entity, pe(2'b01, 8'h57));
        pulse_attack();
        for (int f = 1; f <= 13; f++) begin
            run_frame();
            if (f <= 4)  check($sformatf("sword_on_f%0d", f), sword_entity, 14'h0958);
            if (f == 5)  check("sword_off_f5", sword_entity, C_UNUSED);
            if (f == 6)  pulse_attack();
            if (f == 8)  check("cool_ignore_f8", sword_entity, C_UNUSED);
            if (f == 13) check("cool_ignore_f13", sword_entity, C_UNUSED);
        end
        check("atk_player", player_entity, pe(2'b01, 8'h57));
        pulse_attack();
        run_frame();
        check("rearm_sword", sword_entity, 14'h0958);

        // reset during the second ACTIVE frame
        run_frame();
        check("active_f2", sword_entity, 14'h0958);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check("midrst_player", player_entity, pe(2'b00, 8'h57));
        check("midrst_sword", sword_entity, C_UNUSED);
        check("midrst_state", 14'(u_dut.r_state), 14'd0);
        reset = 1'b0;

        // a press pending at reset must not survive
        pulse_attack();
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_frame();
        check("no_pending_press", sword_entity, C_UNUSED);

        // facing left at 0x50: sword off-grid, player frozen while ACTIVE
        do_reset();
        buttons = C_LEFT;
        run_frames(56);
        check("reach_left", player_entity, pe(2'b11, 8'h50));
        pulse_attack();
        run_frame();
        check("left_sword_id", {10'h0, sword_entity[13:10]}, 14'h000F);
        buttons = C_UP;
        for (int f = 2; f <= 8; f++) begin
            run_frame();
            if (f <= 4) begin
                check($sformatf("left_id_f%0d", f), {10'h0, sword_entity[13:10]}, 14'h000F);
                check($sformatf("frozen_f%0d", f), player_entity, pe(2'b11, 8'h50));
            end
            if (f == 5) check("left_off_f5", sword_entity, C_UNUSED);
            if (f == 6) check("thaw_f6", player_entity, pe(2'b00, 8'h50));
            if (f == 8) check("thaw_move_f8", player_entity, pe(2'b00, 8'h40));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/player_controller.md
PLAYER_CONTROLLER -- requirements
Module: player_controller

Interface
REQ-001 Parameter MOVE_PERIOD, default 8, frames between successive player moves while a direction is held.
REQ-002 Parameter SWORD_FRAMES, default 4, frames the sword entity stays visible per attack.
REQ-003 Parameter COOLDOWN_FRAMES, default 8, frames after the sword retracts before a new attack is accepted.
REQ-004 Parameter PLAYER_ID, default 4'h1, entity ID driven on player_entity.
REQ-005 Parameter SWORD_ID, default 4'h2, entity ID driven on sword_entity while the sword is visible.
REQ-006 clk  input  1  single system clock (pixel clock); one clock domain only.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 buttons  input  4  raw asynchronous pushbuttons {right, left, down, up}, active high.
REQ-009 attack  input  1  raw asynchronous attack button, active high.
REQ-010 vsync  input  1  vertical sync from the VGA sync generator; one rising edge per frame.
REQ-011 player_entity  output  14  {ID[13:10], orientation[9:8], location[7:0]} consumed by the frame buffer controller.
REQ-012 sword_entity  output  14  same format; ID 4'hF marks the channel unused.

Function
REQ-013 buttons, attack and vsync each pass through a 2-flop synchroniser before any use.
REQ-014 frame_tick is a one-cycle pulse on the cycle after a synchronised vsync 0->1 transition; all state updates occur only on frame_tick cycles.
REQ-015 location = {row[7:4], col[3:0]}; col 0..15, row 0..11 (40x40-pixel tiles on 640x480).
REQ-016 Orientation encoding: 00 up, 01 right, 10 down, 11 left.
REQ-017 Direction priority when several held: up > down > left > right.
REQ-018 Move counter increments on each frame_tick, saturating at MOVE_PERIOD-1; a move is taken when a direction is held and the counter is saturated, and the counter then clears to 0.
REQ-019 Orientation updates to the held direction on every frame_tick with a direction held, even if the move is not taken.
REQ-020 Borders clamp without wrap: row 0 up, row 11 down, col 0 left, col 15 right leave location unchanged; orientation still updates.
REQ-021 Attack FSM states IDLE, ACTIVE, COOLDOWN with frame counter.
REQ-022 IDLE->ACTIVE on frame_tick when synchronised attack shows a 0->1 edge since the previous frame_tick (latched press flag, cleared on accept); counter loads SWORD_FRAMES-1.
REQ-023 ACTIVE->COOLDOWN on frame_tick with counter 0, counter loads COOLDOWN_FRAMES-1; COOLDOWN->IDLE on frame_tick with counter 0; otherwise counter decrements per frame_tick.
REQ-024 Presses during ACTIVE or COOLDOWN are discarded (press flag held clear).
REQ-025 In ACTIVE, player movement and orientation are frozen; the move counter still advances.
REQ-026 In ACTIVE, sword_entity = {SWORD_ID, player orientation, tile adjacent in facing direction}; if that tile is off-grid, sword ID = 4'hF.
REQ-027 In IDLE and COOLDOWN, sword_entity = 14'h3C00 (ID 4'hF, orientation 0, location 0).
REQ-028 Outputs are registered; a change decided on a frame_tick cycle is visible on the next cycle and held stable for the rest of the frame.

Reset
REQ-029 On reset: player_entity = {PLAYER_ID, 2'b00, 8'h57}, sword_entity = 14'h3C00, FSM IDLE, all counters, press flag and synchronisers 0.
REQ-030 Reset asserted mid-attack or mid-move returns to REQ-029 values on the next clock edge; no pending press survives.

Structure
REQ-031 Orientation codes, grid limits (GRID_COLS=16, GRID_ROWS=12), UNUSED_ID=4'hF and FSM state encoding live in a shared package for the frame buffer controller and game logic.
REQ-032 One sub-module, frame_tick_gen (vsync synchroniser + edge detect), is instantiated; remaining logic stays in player_controller.

Verification
REQ-033 Reset, then hold up for 20 frames with MOVE_PERIOD=8 -> location 0x57 -> 0x47 at frame 8 -> 0x37 at frame 16; orientation 00.
REQ-034 Start at 0x07, hold up 16 frames -> location stays 0x07, orientation 00; start 0xBF hold right -> stays 0xBF, orientation 01.
REQ-035 Hold up+left together -> only row decrements, orientation 00.
REQ-036 Facing right at 0x57, pulse attack -> sword_entity = {4'h2, 01, 0x58} for exactly 4 frames, then 14'h3C00; second press in cooldown ignored; press after 8 cooldown frames accepted.
REQ-037 Facing left at 0x50, attack -> sword ID 4'hF for the ACTIVE period; player location frozen despite held direction.
REQ-038 Assert reset during ACTIVE at frame 2 -> next cycle outputs equal REQ-029 values and FSM IDLE.
